// File: rtl/ts_stamp_queue_pkg.sv
// ts_stamp_queue_pkg: timestamp window constants shared by the stamp queue and its storage.
package ts_stamp_queue_pkg;
  localparam int TS_LSB_W      = 3;
  localparam int TS_MAX_SPREAD = 3;
  localparam int TS_ALIAS_AGE  = 4;
endpackage

// File: rtl/ts_queue_mem.sv
// ts_queue_mem: entry storage with one write port and a registered read port.
// A write to the address being read is forwarded so a push into an empty queue is visible next cycle.
module ts_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 42
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;
  always_ff @(posedge clock) begin
    if (we) r_mem[waddr] <= wdata;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rdata <= '0;
    else          r_rdata <= (we && waddr == raddr) ? wdata : r_mem[raddr];
  end
  assign rdata = r_rdata;
endmodule

// File: rtl/ts_stamp_queue.sv
// ts_stamp_queue: per-input queue stamping flits with sim_time and holding time to keep heads in the 3-bit window.
// Define TS_STAMP_AGE_CHECK_EN to enable the sticky age_err window-violation check.
module ts_stamp_queue
  import ts_stamp_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TIME_W = 10
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [TIME_W-1:0]   sim_time,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [TS_LSB_W-1:0] out_ts,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_pop,
  output logic                hold_time,
  output logic                age_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TIME_W + DATA_W;
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0]     r_count;
  logic              w_push, w_pop;
  logic [EW-1:0]     w_head;
  logic [TIME_W-1:0] w_head_stamp, w_age;
  assign in_ready     = r_count != CW'(DEPTH);
  assign out_valid    = r_count != '0;
  assign w_push       = in_valid & in_ready;
  assign w_pop        = out_pop & out_valid;
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  // Read address is the post-pop head so the registered read lands on the new head.
  ts_queue_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (w_push),
    .waddr   (r_wr_ptr),
    .wdata   ({sim_time, in_data}),
    .raddr   (w_rd_ptr_nxt),
    .rdata   (w_head)
  );
  assign w_head_stamp = w_head[EW-1 -: TIME_W];
  assign out_ts       = out_valid ? w_head_stamp[TS_LSB_W-1:0] : '0;
  assign out_data     = out_valid ? w_head[DATA_W-1:0] : '0;
  assign w_age        = sim_time - w_head_stamp;
  assign hold_time    = out_valid & (w_age >= TIME_W'(TS_MAX_SPREAD));
`ifdef TS_STAMP_AGE_CHECK_EN
  logic r_age_err;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_age_err <= 1'b0;
    else if (out_valid && w_age >= TIME_W'(TS_ALIAS_AGE)) r_age_err <= 1'b1;
  end
  always @(posedge clock) begin
    if (reset_n && out_valid && w_age >= TIME_W'(TS_ALIAS_AGE))
      $error("ts_stamp_queue: head aged past timestamp window");
  end
  assign age_err = r_age_err;
`else
  assign age_err = 1'b0;
`endif
endmodule

// File: tb/tb_ts_stamp_queue.sv
// tb_ts_stamp_queue: directed and randomized checks of ts_stamp_queue against a queue-based reference model.
module tb_ts_stamp_queue;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  st = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_pop = 1'b0, hold_time, age_err;
  logic [2:0]  out_ts;
  logic [31:0] out_data;
  int errors = 0;
  int checks = 0;
  logic [41:0] mq[$];
  bit m_age_err = 0;

  ts_stamp_queue #(.DEPTH(4), .DATA_W(32), .TIME_W(10)) dut (
    .clock(clock), .reset_n(reset_n), .sim_time(st), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ts(out_ts), .out_data(out_data),
    .out_pop(out_pop), .hold_time(hold_time), .age_err(age_err)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] m_age();
    logic [9:0] s;
    s = mq[0][41:32];
    return st - s;
  endfunction

  function automatic bit m_hold();
    return mq.size() > 0 && m_age() >= 10'd3;
  endfunction

  task automatic tick();
    bit rdy, psh, pp;
    rdy = mq.size() < 4;
    psh = in_valid && rdy;
    pp  = out_pop && mq.size() > 0;
`ifdef TS_STAMP_AGE_CHECK_EN
    if (mq.size() > 0 && m_age() >= 10'd4) m_age_err = 1;
`endif
    if (pp) void'(mq.pop_front());
    if (psh) mq.push_back({st, in_data});
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    mq.delete();
    m_age_err = 0;
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_ts !== 3'd0) begin errors++; $display("FAIL reset_out_ts got=%0d exp=0", out_ts); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if (hold_time !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", hold_time); end
    checks++; if (age_err !== 1'b0) begin errors++; $display("FAIL reset_age_err got=%b exp=0", age_err); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'hDEAD_0000 + i;
      tick();
    end
    in_valid = 1'b0;
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
    checks++; if (hold_time !== 1'b0) begin errors++; $display("FAIL midreset_hold got=%b exp=0", hold_time); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_ghost cyc=%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  task automatic test_latency();
    st = 10'h005; in_valid = 1'b1; in_data = 32'hA5;
    tick();
    in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got=%b exp=1", out_valid); end
    checks++; if (out_ts !== 3'b101) begin errors++; $display("FAIL lat_ts got=%b exp=101", out_ts); end
    checks++; if (out_data !== 32'hA5) begin errors++; $display("FAIL lat_data got=%h exp=a5", out_data); end
    out_pop = 1'b1; tick(); out_pop = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_full();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h101; exp_d[1] = 32'h102; exp_d[2] = 32'h103; exp_d[3] = 32'h105;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + i;
      tick();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", in_ready); end
    in_data = 32'h104; out_pop = 1'b1;
    tick();
    out_pop = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pushpop_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== 32'h101) begin errors++; $display("FAIL full_pushpop_head got=%h exp=101", out_data); end
    in_data = 32'h105;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_refill_ready got=%b exp=0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data !== exp_d[i]) begin errors++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, out_data, exp_d[i]); end
      out_pop = 1'b1; tick();
    end
    out_pop = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_hold();
    st = 10'h010; in_valid = 1'b1; in_data = 32'h1;
    tick();
    st = 10'h011; in_valid = 1'b0; #1;
    checks++; if (hold_time !== 1'b0) begin errors++; $display("FAIL hold_age1 got=%b exp=0", hold_time); end
    tick();
    st = 10'h012; in_valid = 1'b1; in_data = 32'h2; #1;
    checks++; if (hold_time !== 1'b0) begin errors++; $display("FAIL hold_age2 got=%b exp=0", hold_time); end
    tick();
    st = 10'h013; in_valid = 1'b0; #1;
    checks++; if (hold_time !== 1'b1) begin errors++; $display("FAIL hold_age3 got=%b exp=1", hold_time); end
    out_pop = 1'b1; tick(); out_pop = 1'b0; #1;
    checks++; if (out_ts !== 3'b010) begin errors++; $display("FAIL hold_next_ts got=%b exp=010", out_ts); end
    checks++; if (hold_time !== 1'b0) begin errors++; $display("FAIL hold_after_pop got=%b exp=0", hold_time); end
    out_pop = 1'b1; tick(); out_pop = 1'b0;
  endtask

  task automatic test_rollover();
    st = 10'h3FE; in_valid = 1'b1; in_data = 32'h3FE;
    tick();
    in_valid = 1'b0; st = 10'h3FF; #1;
    checks++; if (hold_time !== 1'b0) begin errors++; $display("FAIL roll_age1 got=%b exp=0", hold_time); end
    tick();
    st = 10'h000; #1;
    checks++; if (hold_time !== 1'b0) begin errors++; $display("FAIL roll_age2 got=%b exp=0", hold_time); end
    tick();
    st = 10'h001; #1;
    checks++; if (out_ts !== 3'b110) begin errors++; $display("FAIL roll_ts got=%b exp=110", out_ts); end
    checks++; if (hold_time !== 1'b1) begin errors++; $display("FAIL roll_hold got=%b exp=1", hold_time); end
    out_pop = 1'b1; tick(); out_pop = 1'b0;
  endtask

  task automatic test_random();
    bit adv;
    st = 10'h3E0;
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      out_pop  = ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (in_ready !== (mq.size() < 4)) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, in_ready, mq.size() < 4); end
      checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, mq.size() > 0); end
      checks++; if (hold_time !== m_hold()) begin errors++; $display("FAIL rnd_hold cyc=%0d got=%b exp=%b", c, hold_time, m_hold()); end
      if (mq.size() > 0) begin
        checks++; if (out_ts !== mq[0][34:32]) begin errors++; $display("FAIL rnd_ts cyc=%0d got=%0d exp=%0d", c, out_ts, mq[0][34:32]); end
        checks++; if (out_data !== mq[0][31:0]) begin errors++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", c, out_data, mq[0][31:0]); end
      end
      adv = !m_hold() && ($urandom_range(0, 3) != 0);
      tick();
      if (adv) st = st + 10'd1;
    end
    in_valid = 1'b0; out_pop = 1'b0;
    checks++; if (age_err !== 1'b0) begin errors++; $display("FAIL rnd_age_err got=%b exp=0", age_err); end
  endtask

  task automatic test_age_err();
    do_reset();
    st = 10'h010; in_valid = 1'b1; in_data = 32'h77;
    tick();
    in_valid = 1'b0; st = 10'h014; #1;
    checks++; if (hold_time !== 1'b1) begin errors++; $display("FAIL age_hold got=%b exp=1", hold_time); end
    tick();
    checks++; if (age_err !== m_age_err) begin errors++; $display("FAIL age_set got=%b exp=%b", age_err, m_age_err); end
    out_pop = 1'b1; tick(); out_pop = 1'b0; tick();
    checks++; if (age_err !== m_age_err) begin errors++; $display("FAIL age_sticky got=%b exp=%b", age_err, m_age_err); end
    do_reset();
    checks++; if (age_err !== 1'b0) begin errors++; $display("FAIL age_cleared got=%b exp=0", age_err); end
  endtask

  initial begin
    #1;
    test_reset();
    test_latency();
    test_full();
    test_hold();
    test_rollover();
    test_random();
    test_age_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ts_stamp_queue.md
Name: ts_stamp_queue

Overview:
- Producer side of the 3-bit timestamp earliest-select path.
- Per-input queue that stamps each accepted flit with the current simulation time.
- Presents the head flit's 3-bit timestamp LSBs plus valid to the earliest-selector and pops on grant.
- Drives a time-hold so the global time counter never lets a live head age past the 3-bit comparison window. Spread must be ≤3 for the strictly-earlier table to be unambiguous.

Parameters:
- DEPTH, 4, queue entries; power of 2, ≥2.
- DATA_W, 32, flit payload width.
- TIME_W, 10, width of the full simulation time counter; ≥4.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sim_time  in  TIME_W  current global simulation time; advances by 0 or 1 per cycle.
- in_valid  in  1  producer offers a flit.
- in_data  in  DATA_W  flit payload.
- in_ready  out  1  queue accepts; equals not-full, registered-derived.
- out_valid  out  1  head entry present (feeds selector valid bit).
- out_ts  out  3  head timestamp LSBs (feeds selector ts_in slice).
- out_data  out  DATA_W  head payload.
- out_pop  in  1  selector granted this queue; ignored when out_valid=0.
- hold_time  out  1  global time counter must not advance next cycle.
- age_err  out  1  sticky window-violation flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert handled upstream): rd/wr pointers and count = 0.
  - Outputs: in_ready=1, out_valid=0, out_ts=0, out_data=0, hold_time=0, age_err=0.
  - Reset mid-operation discards all entries; no partial flit survives.
- Storage: each entry holds {full TIME_W stamp, payload}. The stamp is the sim_time value in the accept cycle (in_valid & in_ready).
- Push/pop latency: a flit pushed into an empty queue appears on out_valid/out_ts/out_data on the next rising edge. There is no combinational in-to-out path.
- out_ts = stamp[2:0] of the head entry. Head outputs are registered and update the cycle after a pop to the next entry.
- Pop: out_pop & out_valid removes the head at the edge. out_pop with out_valid=0 is a no-op.
- Full: in_ready=0 when count==DEPTH. Simultaneous push and pop while full is not accepted; in_ready does not depend on out_pop.
- Simultaneous push and pop while not full: count unchanged, both take effect.
- Empty with simultaneous push and pop: the pop is ignored and the push lands.
- Pointers wrap modulo DEPTH. Count is a log2(DEPTH)+1 bit field.
- Age = (sim_time − head stamp) mod 2^TIME_W.
  - hold_time = out_valid & (age ≥ 3), combinational from registered head stamp and sim_time.
  - The global time source ORs all queues' hold_time and freezes while it is asserted. This keeps every live timestamp within 3 of sim_time, and therefore any pair of heads within 3 of each other.
- Wrap-around: stamps are stored full width, so age is correct across sim_time rollover and across 3-bit LSB rollover (e.g. head 0x3FE, sim_time 0x001 → age 3).
- States (implicit): EMPTY (count 0), ACTIVE (0<count<DEPTH), FULL (count==DEPTH). Transitions follow push/pop as above.

Optional Feature:
- Macro: TS_STAMP_AGE_CHECK_EN.
- Defined: age_err sets at the edge where out_valid & age ≥ 4, i.e. the time source ignored hold_time. It stays set until reset. A simulation $error is also issued.
- Undefined: age_err tied to 0; no check logic.

Decomposition:
- Shared package: TS_LSB_W=3, TS_MAX_SPREAD=3, TS_ALIAS_AGE=4.
- One natural sub-module, ts_queue_mem: DEPTH×(TIME_W+DATA_W) register array with write port and registered read port. ts_stamp_queue owns pointers, count, head register and age logic.

Test Plan:
- Reset: drive reset_n=0 mid-stream with 3 entries queued → after reset in_ready=1, out_valid=0, out_ts=0, hold_time=0; no old flits emerge.
- Latency and stamping: push data 0xA5 at sim_time=0x005 into empty queue → next cycle out_valid=1, out_ts=3'b101, out_data=0xA5.
- Full: push 4 flits without pop → in_ready=0. Push with out_pop in the full cycle → not accepted, count becomes 3. The next push is accepted.
- Hold: head stamp 0x010, sim_time steps 0x011, 0x012, 0x013 → hold_time=0, 0, 1. Pop at 0x013 with next head stamp 0x012 → hold_time=0.
- Rollover: head stamp 0x3FE, sim_time 0x001 → out_ts=3'b110, hold_time=1.
- Age error (macro defined): force sim_time to 0x014 with head 0x010 despite hold_time → age_err=1 next edge and stays 1 until reset_n=0. With macro undefined → age_err stays 0.
